// File: rtl/ethernet_header_inserter_hls_deadlock_detector.sv
// Deadlock aggregator for the ethernet_header_inserter dataflow region.
// Blocking from any process monitor must persist for THRESHOLD consecutive
// cycles before a deadlock is declared. The report is sticky until clear
// or reset.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | no stall in progress, all report outputs held at zero
// WATCH    | stall episode in progress, counting toward THRESHOLD
// DEADLOCK | deadlock declared; sticky until clear or reset
module ethernet_header_inserter_hls_deadlock_detector #(
  parameter int NUM_MONITORS = 3,
  parameter int THRESHOLD    = 1024,
  parameter int CNT_W        = 16,
  parameter int IDX_W        = 2
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [NUM_MONITORS-1:0] block_sigs,
  input  logic                    all_idle,
  input  logic                    clear,
  output logic                    deadlock,
  output logic                    deadlock_valid,
  output logic [NUM_MONITORS-1:0] blocked_mask,
  output logic [IDX_W-1:0]        first_idx,
  output logic [CNT_W-1:0]        blocked_cycles
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WATCH    = 2'd1,
    DEADLOCK = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] THR_M1  = CNT_W'(THRESHOLD - 1);
  localparam logic [CNT_W-1:0] THR     = CNT_W'(THRESHOLD);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t                  state, state_nxt;
  logic [CNT_W-1:0]        cnt, cnt_nxt;
  logic [NUM_MONITORS-1:0] mask_nxt;
  logic [IDX_W-1:0]        first_nxt;
  logic                    dl_nxt;
  logic                    dv_nxt;
  logic                    stalled;
  logic [IDX_W-1:0]        low_idx;

  assign stalled        = (|block_sigs) & ~all_idle;
  assign blocked_cycles = cnt;

  // Priority encoder: lowest set bit of block_sigs.
  always_comb begin
    low_idx = '0;
    for (int i = NUM_MONITORS - 1; i >= 0; i--) begin
      if (block_sigs[i]) low_idx = IDX_W'(i);
    end
  end

  // Next-state and next-output computation; clear overrides everything.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    mask_nxt  = blocked_mask;
    first_nxt = first_idx;
    dl_nxt    = deadlock;
    dv_nxt    = 1'b0;
    if (clear) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
      mask_nxt  = '0;
      first_nxt = '0;
      dl_nxt    = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          cnt_nxt   = '0;
          mask_nxt  = '0;
          first_nxt = '0;
          dl_nxt    = 1'b0;
          if (stalled) begin
            state_nxt = WATCH;
            cnt_nxt   = CNT_W'(1);
            mask_nxt  = block_sigs;
            first_nxt = low_idx;
          end
        end
        WATCH: begin
          if (!stalled) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
            mask_nxt  = '0;
            first_nxt = '0;
          end else if (cnt == THR_M1) begin
            state_nxt = DEADLOCK;
            cnt_nxt   = THR;
            mask_nxt  = blocked_mask | block_sigs;
            dl_nxt    = 1'b1;
            dv_nxt    = 1'b1;
          end else begin
            cnt_nxt   = cnt + CNT_W'(1);
            mask_nxt  = blocked_mask | block_sigs;
          end
        end
        DEADLOCK: begin
          dl_nxt = 1'b1;
          if (stalled) begin
            if (cnt != CNT_MAX) cnt_nxt = cnt + CNT_W'(1);
            mask_nxt = blocked_mask | block_sigs;
          end
        end
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
          mask_nxt  = '0;
          first_nxt = '0;
          dl_nxt    = 1'b0;
        end
      endcase
    end
  end

  // State and report registers; async reset clears everything immediately.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      cnt            <= '0;
      blocked_mask   <= '0;
      first_idx      <= '0;
      deadlock       <= 1'b0;
      deadlock_valid <= 1'b0;
    end else begin
      state          <= state_nxt;
      cnt            <= cnt_nxt;
      blocked_mask   <= mask_nxt;
      first_idx      <= first_nxt;
      deadlock       <= dl_nxt;
      deadlock_valid <= dv_nxt;
    end
  end

endmodule

// File: tb/tb_ethernet_header_inserter_hls_deadlock_detector.sv
// Directed bench: THRESHOLD=8 with a 16-bit counter, plus a 4-bit counter
// instance sharing the same stimulus to observe saturation.
module tb_ethernet_header_inserter_hls_deadlock_detector;

  logic       clock;
  logic       reset;
  logic [2:0] block_sigs;
  logic       all_idle;
  logic       clear;

  logic        deadlock, deadlock_valid;
  logic [2:0]  blocked_mask;
  logic [1:0]  first_idx;
  logic [15:0] blocked_cycles;

  logic        s_deadlock, s_deadlock_valid;
  logic [2:0]  s_blocked_mask;
  logic [1:0]  s_first_idx;
  logic [3:0]  s_blocked_cycles;

  int vectors     = 0;
  int miscompares = 0;

  ethernet_header_inserter_hls_deadlock_detector #(
    .NUM_MONITORS(3), .THRESHOLD(8), .CNT_W(16), .IDX_W(2)
  ) dut (
    .clock(clock), .reset(reset), .block_sigs(block_sigs),
    .all_idle(all_idle), .clear(clear),
    .deadlock(deadlock), .deadlock_valid(deadlock_valid),
    .blocked_mask(blocked_mask), .first_idx(first_idx),
    .blocked_cycles(blocked_cycles)
  );

  ethernet_header_inserter_hls_deadlock_detector #(
    .NUM_MONITORS(3), .THRESHOLD(8), .CNT_W(4), .IDX_W(2)
  ) dut_sat (
    .clock(clock), .reset(reset), .block_sigs(block_sigs),
    .all_idle(all_idle), .clear(clear),
    .deadlock(s_deadlock), .deadlock_valid(s_deadlock_valid),
    .blocked_mask(s_blocked_mask), .first_idx(s_first_idx),
    .blocked_cycles(s_blocked_cycles)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic dl, input logic dv,
                         input logic [2:0] m, input logic [1:0] fi, input logic [15:0] c);
    chk({tag, ".deadlock"},       32'(deadlock),       32'(dl));
    chk({tag, ".deadlock_valid"}, 32'(deadlock_valid), 32'(dv));
    chk({tag, ".blocked_mask"},   32'(blocked_mask),   32'(m));
    chk({tag, ".first_idx"},      32'(first_idx),      32'(fi));
    chk({tag, ".blocked_cycles"}, 32'(blocked_cycles), 32'(c));
  endtask

  initial begin
    reset = 1'b1; block_sigs = 3'b000; all_idle = 1'b0; clear = 1'b0;
    #1;
    chk_all("reset", 1'b0, 1'b0, 3'b000, 2'd0, 16'd0);
    tick(2);
    reset = 1'b0;
    tick(2);
    chk_all("idle", 1'b0, 1'b0, 3'b000, 2'd0, 16'd0);

    // Single blocker held through threshold and beyond.
    block_sigs = 3'b100;
    tick(7);
    chk_all("s1_pre", 1'b0, 1'b0, 3'b100, 2'd2, 16'd7);
    tick(1);
    chk_all("s1_decl", 1'b1, 1'b1, 3'b100, 2'd2, 16'd8);
    tick(1);
    chk("s1_pulse_end", 32'(deadlock_valid), 32'd0);
    chk("s1_cnt9", 32'(blocked_cycles), 32'd9);
    tick(99);
    chk("s1_cnt108", 32'(blocked_cycles), 32'd108);
    chk("sat_cnt15", 32'(s_blocked_cycles), 32'd15);
    chk("sat_deadlock", 32'(s_deadlock), 32'd1);
    block_sigs = 3'b000;
    tick(3);
    chk_all("s1_sticky", 1'b1, 1'b0, 3'b100, 2'd2, 16'd108);
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    chk_all("s1_clear", 1'b0, 1'b0, 3'b000, 2'd0, 16'd0);

    // Episode one short of threshold aborts back to IDLE.
    block_sigs = 3'b010;
    tick(7);
    chk_all("s2_pre", 1'b0, 1'b0, 3'b010, 2'd1, 16'd7);
    block_sigs = 3'b000;
    tick(1);
    chk_all("s2_abort", 1'b0, 1'b0, 3'b000, 2'd0, 16'd0);

    // Changing pattern accumulates mask, first_idx fixed at episode start.
    block_sigs = 3'b110;
    tick(3);
    chk_all("s3_mid", 1'b0, 1'b0, 3'b110, 2'd1, 16'd3);
    block_sigs = 3'b001;
    tick(5);
    chk_all("s3_decl", 1'b1, 1'b1, 3'b111, 2'd1, 16'd8);
    // Clear while still stalled: clear-cycle sample discarded.
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    chk_all("s3_clear", 1'b0, 1'b0, 3'b000, 2'd0, 16'd0);
    tick(1);
    chk_all("s3_restart", 1'b0, 1'b0, 3'b001, 2'd0, 16'd1);

    // all_idle aborts an active episode and masks blocking entirely.
    all_idle = 1'b1;
    tick(1);
    chk_all("s4_abort", 1'b0, 1'b0, 3'b000, 2'd0, 16'd0);
    block_sigs = 3'b111;
    tick(20);
    chk_all("s4_idle20", 1'b0, 1'b0, 3'b000, 2'd0, 16'd0);
    all_idle = 1'b0;

    // Async reset mid-WATCH at cnt=5.
    block_sigs = 3'b011;
    tick(5);
    chk_all("s5_watch", 1'b0, 1'b0, 3'b011, 2'd0, 16'd5);
    #2 reset = 1'b1;
    #1;
    chk_all("s5_async_watch", 1'b0, 1'b0, 3'b000, 2'd0, 16'd0);
    tick(1);
    reset = 1'b0;

    // Async reset in DEADLOCK.
    tick(8);
    chk_all("s6_decl", 1'b1, 1'b1, 3'b011, 2'd0, 16'd8);
    tick(2);
    #2 reset = 1'b1;
    #1;
    chk_all("s6_async_dl", 1'b0, 1'b0, 3'b000, 2'd0, 16'd0);
    chk("s6_sat_dl", 32'(s_deadlock), 32'd0);
    tick(1);
    reset = 1'b0;
    block_sigs = 3'b000;
    tick(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ethernet_header_inserter_hls_deadlock_detector.md
Name: ethernet_header_inserter_hls_deadlock_detector

Overview:
- Top-level deadlock aggregator for the ethernet_header_inserter HLS dataflow region.
- Consumes the registered `block` outputs of all per-process deadlock monitors, plus the region-wide idle indication.
- Declares a deadlock only when blocking persists for THRESHOLD consecutive cycles.
- Latches a sticky report: which processes were blocked, which was first, and how long the stall has lasted.

Parameters:
- NUM_MONITORS, 3, number of per-process monitor `block` inputs (>=1).
- THRESHOLD, 1024, consecutive stalled cycles required to declare deadlock (>=2, < 2**CNT_W).
- CNT_W, 16, width of stall cycle counter.
- IDX_W, 2, width of process index output (2**IDX_W >= NUM_MONITORS).

Ports:
- clock  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- block_sigs  in  NUM_MONITORS  bit i = `block` output of monitor i.
- all_idle  in  1  dataflow region idle; while high, blocking is ignored.
- clear  in  1  synchronous clear of report and FSM.
- deadlock  out  1  sticky deadlock flag.
- deadlock_valid  out  1  one-cycle pulse on deadlock declaration.
- blocked_mask  out  NUM_MONITORS  OR of block_sigs over the current stall episode.
- first_idx  out  IDX_W  lowest set index of block_sigs at stall start.
- blocked_cycles  out  CNT_W  consecutive stalled cycles, saturating.

Behaviour:
- stalled = (|block_sigs) & ~all_idle, sampled each rising edge.
- Reset (async assert, sync-safe deassert handled externally):
  - state=IDLE.
  - All outputs 0; counter 0.
- FSM states: IDLE, WATCH, DEADLOCK. All outputs are registered.
- IDLE:
  - If stalled: go to WATCH, cnt=1, blocked_mask=block_sigs, first_idx=lowest set bit index of block_sigs.
  - Else: hold all zero.
- WATCH:
  - If !stalled: go to IDLE; cnt, blocked_mask and first_idx return to 0.
  - Else if cnt==THRESHOLD-1: go to DEADLOCK, cnt=THRESHOLD, blocked_mask|=block_sigs, deadlock=1, deadlock_valid=1 for exactly one cycle.
  - Else: cnt+=1, blocked_mask|=block_sigs.
  - first_idx is never updated in WATCH.
- DEADLOCK (sticky):
  - deadlock stays 1 regardless of inputs.
  - While stalled: cnt+=1, saturating at 2**CNT_W-1 with no wrap; blocked_mask|=block_sigs.
  - If !stalled: cnt holds its value.
  - Only clear or reset leaves this state.
- Latency: deadlock rises in the cycle after the THRESHOLD-th consecutive stalled sample.
- blocked_cycles = cnt at all times.
- clear has priority over every transition in every state:
  - Next state IDLE; all outputs 0.
  - The input sample in the clear cycle is discarded; counting restarts on the next stalled sample.
- all_idle=1 simultaneous with block bits: treated as not stalled. In WATCH this aborts the episode.
- A block_sigs pattern changing mid-episode (non-zero to different non-zero) does not restart counting; the mask accumulates.
- Reset asserted mid-operation: immediate return to IDLE with all outputs 0, including in DEADLOCK.

Test Plan:
- Bench uses THRESHOLD=8, NUM_MONITORS=3.
- block_sigs=3'b100, all_idle=0 held 8 cycles -> deadlock=1 and deadlock_valid pulse in cycle 9; first_idx=2, blocked_mask=3'b100, blocked_cycles=8.
- block_sigs=3'b010 for 7 cycles, then 0 -> no deadlock; FSM back in IDLE; blocked_cycles=0, blocked_mask=0.
- block_sigs=3'b110 for 3 cycles, then 3'b001 for 5 cycles -> deadlock; first_idx=1, blocked_mask=3'b111.
- Blocked with all_idle=1 for 20 cycles -> deadlock stays 0, blocked_cycles=0.
- After deadlock: hold blocked 100 cycles -> blocked_cycles=108, deadlock stays high after block_sigs drops. Pulse clear -> all outputs 0 next cycle. With CNT_W=4, long stall saturates blocked_cycles at 15.
- Assert reset asynchronously mid-WATCH (cnt=5) and in DEADLOCK -> outputs 0 immediately, before the next clock edge.
